// File: rtl/mem_access_unit.sv
// mem_access_unit: core-side load/store initiator that turns byte/half/word requests into ram_control word ops
// Ports:
//   clk, reset_n                      clock, synchronous active-low reset
//   req_valid/req_ready               request handshake (ready only in IDLE)
//   req_we, req_size, req_unsigned    store flag, 00 byte / 01 half / 10 word, zero-extend loads
//   req_addr, req_wdata               byte address, LSB-justified store data
//   resp_valid, resp_err, resp_rdata  one-cycle completion pulse with error flag and load data
//   ram_rd_start, ram_rd_addr_base    read request to ram_control (halfword base)
//   ram_rd_done, ram_rd_data_out      read completion and word
//   ram_wr_start, ram_wr_addr_base    write request to ram_control (halfword base)
//   ram_wr_data_in, ram_wr_done       word to write and write completion
module mem_access_unit #(
  parameter int DEPTH          = 4096,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        ram_wr_start,
  output logic        ram_rd_start,
  output logic [31:0] ram_wr_addr_base,
  output logic [31:0] ram_wr_data_in,
  output logic [31:0] ram_rd_addr_base,
  input  logic        ram_wr_done,
  input  logic        ram_rd_done,
  input  logic [31:0] ram_rd_data_out
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, CHECK, RD, WR, RMW_RD, RMW_WR, RESP} state_t;
  state_t state, state_n;
  logic r_we, r_uns, err, gap;
  logic [1:0] r_size;
  logic [31:0] r_addr, r_wdata, wword, rdata;
  logic [CW-1:0] cnt;
  logic [31:0] base, mask, merged, ext;
  logic [32:0] base_p1;
  logic [4:0] sh;
  logic [15:0] h;
  logic [7:0] b;
  logic bad, rd_wait, wr_act, done_hit, tmo;
  // Word-aligned byte address shifted down one: halfword index of the low half.
  assign base    = {1'b0, r_addr[31:2], 1'b0};
  assign base_p1 = {1'b0, base} + 33'd1;
  assign bad     = (r_size == 2'b11) | (r_size == 2'b01 & r_addr[0]) |
                   (r_size == 2'b10 & |r_addr[1:0]) | (base_p1 >= 33'(DEPTH));
  assign rd_wait = state == RD | state == RMW_RD;
  // The first RMW_WR cycle keeps wr_start low so it never follows rd_start back to back.
  assign wr_act   = state == WR | (state == RMW_WR & ~gap);
  assign done_hit = (rd_wait & ram_rd_done) | (wr_act & ram_wr_done);
  assign tmo      = (rd_wait | state == WR | state == RMW_WR) & cnt == CW'(TIMEOUT_CYCLES - 1);
  assign sh     = r_size == 2'b00 ? {r_addr[1:0], 3'b0} : {r_addr[1], 4'b0};
  assign mask   = (r_size == 2'b00 ? 32'h0000_00ff : 32'h0000_ffff) << sh;
  assign merged = (ram_rd_data_out & ~mask) | ((r_wdata << sh) & mask);
  assign h      = ram_rd_data_out[{r_addr[1], 4'b0} +: 16];
  assign b      = ram_rd_data_out[{r_addr[1:0], 3'b0} +: 8];
  assign ext    = r_size == 2'b00 ? {{24{~r_uns & b[7]}}, b} :
                  r_size == 2'b01 ? {{16{~r_uns & h[15]}}, h} : ram_rd_data_out;
  always_ff @(posedge clk)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = req_valid ? CHECK : IDLE;
      CHECK:   state_n = bad ? RESP : !r_we ? RD : r_size == 2'b10 ? WR : RMW_RD;
      RD:      state_n = (ram_rd_done | tmo) ? RESP : RD;
      RMW_RD:  state_n = ram_rd_done ? RMW_WR : tmo ? RESP : RMW_RD;
      WR:      state_n = (ram_wr_done | tmo) ? RESP : WR;
      RMW_WR:  state_n = (done_hit | tmo) ? RESP : RMW_WR;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    req_ready        = state == IDLE;
    resp_valid       = state == RESP;
    resp_err         = resp_valid & err;
    resp_rdata       = resp_valid ? rdata : 32'd0;
    ram_rd_start     = rd_wait;
    ram_wr_start     = wr_act;
    ram_rd_addr_base = base;
    ram_wr_addr_base = base;
    ram_wr_data_in   = wword;
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      wword   <= '0;
      rdata   <= '0;
      err     <= 1'b0;
      gap     <= 1'b0;
      cnt     <= '0;
    end else begin
      // Counter restarts whenever the state changes, i.e. on entry to each wait state.
      cnt <= (state_n != state) ? '0 : cnt + 1'b1;
      gap <= state == RMW_RD & state_n == RMW_WR;
      if (state == IDLE & req_valid) begin
        r_we    <= req_we;
        r_size  <= req_size;
        r_uns   <= req_unsigned;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        err     <= 1'b0;
        rdata   <= '0;
      end
      if (state == CHECK) begin
        err   <= bad;
        wword <= r_wdata;
      end
      if (state == RD & ram_rd_done) rdata <= ext;
      if (state == RMW_RD & ram_rd_done) wword <= merged;
      if (tmo & ~done_hit) err <= 1'b1;
    end
endmodule
